// File: rtl/addsub_pkg.sv
// Shared constants and state encoding for the nibble-serial add/subtract sequencer.
package addsub_pkg;

    localparam int unsigned NIBBLE_W = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addsub_state_e;

endpackage

// File: rtl/addsub_slice.sv
// Combinational 4-bit add/subtract slice; b is inverted in subtract mode and cin supplies the +1.
module addsub_slice
    import addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                mode,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout,
    output logic                c_msb_in
);

    logic [NIBBLE_W-1:0] b_eff;
    logic [NIBBLE_W-1:0] low_sum;

    always_comb begin
        b_eff    = (mode == MODE_SUB) ? ~b : b;
        // Low three bits added separately so the carry into bit 3 is visible for overflow.
        low_sum  = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b_eff[NIBBLE_W-2:0]}
                 + {{(NIBBLE_W-1){1'b0}}, cin};
        c_msb_in = low_sum[NIBBLE_W-1];
        sum      = {a[NIBBLE_W-1] ^ b_eff[NIBBLE_W-1] ^ c_msb_in, low_sum[NIBBLE_W-2:0]};
        cout     = (a[NIBBLE_W-1] & b_eff[NIBBLE_W-1])
                 | (c_msb_in & (a[NIBBLE_W-1] ^ b_eff[NIBBLE_W-1]));
    end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Multi-precision add/subtract sequencer: one 4-bit slice reused LSB nibble first,
// carry chained through a register, flags captured on the final pass.
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned CntW    = $clog2(NIBBLES);

    addsub_state_e state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [NIBBLE_W-1:0] s_sum;
    logic                s_cout;
    logic                s_cmsb;

    addsub_slice u_slice (
        .a        (a_q[cnt_q*NIBBLE_W +: NIBBLE_W]),
        .b        (b_q[cnt_q*NIBBLE_W +: NIBBLE_W]),
        .mode     (mode_q),
        .cin      (carry_q),
        .sum      (s_sum),
        .cout     (s_cout),
        .c_msb_in (s_cmsb)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    // Subtract is A + ~B + 1, so the initial carry equals mode.
                    carry_d = mode;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                result_d[cnt_q*NIBBLE_W +: NIBBLE_W] = s_sum;
                carry_d = s_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntW'(NIBBLES - 1)) begin
                    cout_d  = s_cout;
                    ovf_d   = s_cmsb ^ s_cout;
                    zero_d  = (result_d == '0);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= MODE_ADD;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: stimulus pushes expected results, a monitor
// pops and compares on every done pulse.
module tb_serial_addsub_ctrl;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             mode;
    logic             busy, done, carry_out, overflow, zero;
    logic [WIDTH-1:0] result;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             cout;
        logic             ovf;
        logic             zf;
        int               done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("carry_out", 32'(carry_out), 32'(e.cout));
                check("overflow", 32'(overflow), 32'(e.ovf));
                check("zero", 32'(zero), 32'(e.zf));
                check("latency", 32'(cyc), 32'(e.done_cyc));
            end
        end
    end

    // Drive start for one cycle (called at a negedge) and queue the expected outcome.
    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tm, input logic [WIDTH-1:0] er, input logic ec,
                         input logic eo, input logic ez);
        exp_t e;
        start = 1'b1;
        a     = ta;
        b     = tb;
        mode  = tm;
        e.res = er; e.cout = ec; e.ovf = eo; e.zf = ez;
        e.done_cyc = cyc + 5;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is high; counts busy cycles on the way.
    task automatic wait_done(output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) return;
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        n_checks++;
        n_errors++;
        $display("FAIL done_timeout: got no done within 20 cycles, expected done");
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tm, input logic [WIDTH-1:0] er, input logic ec,
                          input logic eo, input logic ez);
        int bc;
        issue(ta, tb, tm, er, ec, eo, ez);
        wait_done(bc);
        check("busy_cycles", 32'(bc), 32'd4);
        @(negedge clk);
    endtask

    initial begin
        int bc;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; mode = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({carry_out, overflow, zero}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op(16'h5A5A, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Start while busy is ignored; start in the DONE cycle is accepted.
        issue(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 16'h1111; b = 16'h2222; mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc);
        issue(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        wait_done(bc);
        check("busy_cycles_b2b", 32'(bc), 32'd4);
        @(negedge clk);
        check("done_single", 32'(done), 32'd0);

        // Reset in RUN cycle 2 aborts with no done pulse; nothing is queued for it.
        start = 1'b1; a = 16'hAAAA; b = 16'h5555; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", 32'({carry_out, overflow, zero}), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run_op(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
